// File: rtl/fft_output_reorder.sv
// Reorders bit-reversed radix-2 DIF FFT results into natural order using a
// ping-pong frame buffer, streaming one complex sample per cycle.
module fft_output_reorder #(
  parameter int BW    = 16,
  parameter int LOG2N = 6,
  localparam int N    = 2**LOG2N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_real0,
  input  logic [BW-1:0]    in_imag0,
  input  logic [BW-1:0]    in_real1,
  input  logic [BW-1:0]    in_imag1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_real,
  output logic [BW-1:0]    out_imag,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             overflow,
  output logic [0:0]       rd_state
);

  // Handshakes: a beat/sample transfers on a rising edge where valid && ready.
  // The input side is never stalled; a beat offered while in_ready is low is
  // dropped and flagged through the sticky overflow bit.

  typedef enum logic {R_IDLE, R_STREAM} r_state_t;

  r_state_t             state_q, state_d;
  logic [2*BW-1:0]      bank_mem [2][N];
  logic [1:0]           full;
  logic                 wbank, rbank, rbank_d;
  logic [LOG2N-2:0]     wcnt;
  logic [LOG2N-1:0]     rcnt, rcnt_d;
  logic                 wr_fire, wr_last;
  logic [LOG2N-1:0]     waddr0, waddr1;
  logic                 load, load_bank, clr_full, valid_d;
  logic [LOG2N-1:0]     load_addr;
  logic [2*BW-1:0]      rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready = !full[wbank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = (wcnt == {(LOG2N-1){1'b1}});
  assign waddr0   = bitrev({wcnt, 1'b0});
  assign waddr1   = bitrev({wcnt, 1'b1});
  assign rd_state = state_q;

  // Frame storage is deliberately left unreset; full flags gate all reads.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_mem[wbank][waddr0] <= {in_real0, in_imag0};
      bank_mem[wbank][waddr1] <= {in_real1, in_imag1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      full     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wr_last) begin
          full[wbank] <= 1'b1;
          wbank       <= !wbank;
        end
      end
      // A set and a clear in the same cycle always target different banks.
      if (clr_full) full[rbank] <= 1'b0;
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_bank = rbank;
    load_addr = rcnt;
    clr_full  = 1'b0;
    rbank_d   = rbank;
    rcnt_d    = rcnt;
    valid_d   = out_valid;
    case (state_q)
      R_IDLE: begin
        if (full[rbank]) begin
          load      = 1'b1;
          load_addr = '0;
          valid_d   = 1'b1;
          state_d   = R_STREAM;
        end
      end
      R_STREAM: begin
        if (out_valid && out_ready) begin
          if (rcnt != {LOG2N{1'b1}}) begin
            rcnt_d    = rcnt + 1'b1;
            load      = 1'b1;
            load_addr = rcnt + 1'b1;
          end else begin
            clr_full = 1'b1;
            rbank_d  = !rbank;
            rcnt_d   = '0;
            // Gapless hand-over when the other bank is already complete.
            if (full[!rbank]) begin
              load      = 1'b1;
              load_bank = !rbank;
              load_addr = '0;
            end else begin
              valid_d = 1'b0;
              state_d = R_IDLE;
            end
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign rd_word = bank_mem[load_bank][load_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= R_IDLE;
      rbank     <= 1'b0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rbank     <= rbank_d;
      rcnt      <= rcnt_d;
      out_valid <= valid_d;
      if (load) begin
        out_real  <= rd_word[2*BW-1:BW];
        out_imag  <= rd_word[BW-1:0];
        out_index <= load_addr;
        out_last  <= (load_addr == {LOG2N{1'b1}});
      end
    end
  end

endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Downstream of the in-place radix-2 DIF FFT core.
- Consumes the core's two-sample-per-cycle result stream, which arrives in bit-reversed index order.
- Rewrites each frame into natural order through a ping-pong frame buffer.
- Streams one complex sample per cycle with a valid/ready handshake, tagged with frame index and last flag, to the next stage (DMA / output FIFO).

Parameters:
- BW, 16, bit width of each real/imag component (matches core output width)
- LOG2N, 6, log2 of FFT frame length
- N, 2**LOG2N, points per frame (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  core output beat valid (driven from core output_start qualifier)
- in_ready  out  1  block can accept a beat this cycle
- in_real0  in  BW  upper butterfly output, real
- in_imag0  in  BW  upper butterfly output, imag
- in_real1  in  BW  lower butterfly output, real
- in_imag1  in  BW  lower butterfly output, imag
- out_valid  out  1  out_real/out_imag/out_index/out_last valid
- out_ready  in  1  downstream accepts the sample
- out_real  out  BW  natural-order sample, real
- out_imag  out  BW  natural-order sample, imag
- out_index  out  LOG2N  natural frequency index of the current sample
- out_last  out  1  high on index N-1
- overflow  out  1  sticky: a beat arrived while in_ready was low

Behaviour:
- Storage: two frame banks, N x 2BW each, register array, asynchronous read. Buffer contents are not reset.
- Write side:
  - Counter wcnt (0..N/2-1) and pointer wbank.
  - Beat accepted when in_valid && in_ready.
  - Beat k writes {in_real0,in_imag0} at address bitrev(2k) and {in_real1,in_imag1} at address bitrev(2k+1), LOG2N-bit reversal.
  - On acceptance of beat N/2-1: full[wbank] is set, wbank toggles, wcnt wraps to 0.
- in_ready = !full[wbank] (combinational).
- Overflow: in_valid && !in_ready drops the beat, leaves wcnt unchanged, and sets overflow. overflow is cleared only by rst.
- Read FSM:
  - R_IDLE: wait for full[rbank]; then load the output register with address 0 and go to R_STREAM.
  - R_STREAM: when out_valid && out_ready:
    - if rcnt < N-1: increment rcnt and load the next address.
    - if rcnt == N-1: clear full[rbank], toggle rbank, reset rcnt to 0. If the other bank is already full, load its address 0 in the same cycle and stay in R_STREAM (gapless). Otherwise drop out_valid and go to R_IDLE.
- Output register hold: while out_valid && !out_ready, out_real/out_imag/out_index/out_last hold stable.
- Latency: out_valid rises on the edge after the edge that accepted the final beat of a frame. Throughput is 1 sample/cycle with out_ready high.
- Simultaneous events:
  - The write side setting full[wbank] and the read side clearing full[rbank] in the same cycle act on different banks; both take effect.
  - If the read side frees a bank in the cycle a beat is refused, the refused beat is still dropped; in_ready rises the next cycle.
- Reset values (rst asserted on any edge, including mid-frame):
  - out_valid=0, out_real=0, out_imag=0, out_index=0, out_last=0, overflow=0
  - full=00, wbank=0, rbank=0, wcnt=0, rcnt=0, FSM=R_IDLE
  - Partial frames on both sides are discarded.

Test Plan:
- Single frame, out_ready=1: 32 beats with in_real0=bitrev(2k), in_real1=bitrev(2k+1), imag=~real (beat 1 carries 16 and 48). Required: out_valid rises 1 cycle after beat 31; out_real=0..63 consecutively; out_index matches; out_last only at 63; no gaps.
- Back-to-back frames: frame A (real=idx) immediately followed by frame B (real=idx+100), out_ready=1. Required: 128 contiguous samples with no bubble at the 63->0 boundary; in_ready stays 1 throughout.
- Backpressure: out_ready toggles 1,0,0,1 repeating during the readout. Required: outputs hold while out_ready=0; the sequence is still 0..63 with no duplicate or skipped sample.
- Overflow: out_ready=0, feed 3 full frames. Required: in_ready falls after beat 31 of frame 2; frame-3 beats are dropped; overflow=1 and stays 1. Raising out_ready then yields frames 1 and 2 intact.
- Reset mid-operation: assert rst at beat 10 of a frame, and again mid-readout at index 20. Required: next cycle out_valid=0, in_ready=1, overflow=0. A fresh full frame then reads out 0..63 correctly.
